// File: rtl/noekeon_word_loader.sv
// rtl/noekeon_word_loader.sv - word-stream front end assembling 128-bit key/data blocks for the Noekeon core.
// Define NOEKEON_LOADER_BYTESWAP_EN to byte-reverse every host word in and out (little-endian host).
module noekeon_word_loader #(
  parameter int WORD_W = 32
) (
  input  logic              inClk,
  input  logic              inReset,
  input  logic              inWordValid,
  output logic              outWordReady,
  input  logic [WORD_W-1:0] inWordData,
  input  logic              inWordIsKey,
  output logic              outSeqErr,
  output logic              outCoreDataWr,
  output logic              outCoreKeyWr,
  output logic [127:0]      outCoreData,
  output logic [127:0]      outCoreKey,
  input  logic              inCoreBusy,
  input  logic [127:0]      inCoreResult,
  output logic              outResValid,
  input  logic              inResReady,
  output logic [WORD_W-1:0] outResData,
  output logic              outResLast
);

  localparam int WORDS = 128 / WORD_W;
  localparam int CW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(WORDS - 1);

  typedef enum logic [2:0] {
    S_FILL,
    S_ISSUE,
    S_WAIT_START,
    S_WAIT_DONE,
    S_DRAIN
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic            r_word_ready;
  logic            r_seq_err;
  logic            r_data_wr;
  logic            r_key_wr;
  logic            r_res_valid;
  logic            r_res_last;
  logic [127:0]    r_core_data;
  logic [127:0]    r_core_key;
  logic [127:0]    r_buf;
  logic [127:0]    r_res;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   r_res_cnt;
  logic            r_type;
  logic            r_op_key;

  logic [WORD_W-1:0] w_word;
  logic              w_accept;
  logic              w_mismatch;
  logic [CW-1:0]     w_beat;
  logic              w_block_done;
  logic [127:0]      w_block;
  logic              w_issue;
  logic              w_capture;
  logic              w_res_hs;
  logic              w_res_done;
  logic [CW-1:0]     w_res_cnt_inc;

`ifdef NOEKEON_LOADER_BYTESWAP_EN
  function automatic logic [WORD_W-1:0] f_bswap(input logic [WORD_W-1:0] x);
    logic [WORD_W-1:0] y;
    y = '0;
    for (int i = 0; i < WORD_W / 8; i++) y[8*i +: 8] = x[WORD_W-8-8*i +: 8];
    return y;
  endfunction
  assign w_word     = f_bswap(inWordData);
  assign outResData = f_bswap(r_res[127 -: WORD_W]);
`else
  assign w_word     = inWordData;
  assign outResData = r_res[127 -: WORD_W];
`endif

  // A type change mid-fill restarts the block with this word as its first beat.
  assign w_accept      = inWordValid && r_word_ready;
  assign w_mismatch    = w_accept && (r_cnt != '0) && (inWordIsKey != r_type);
  assign w_beat        = w_mismatch ? '0 : r_cnt;
  assign w_block_done  = w_accept && (w_beat == LAST_BEAT);
  assign w_block       = (r_buf << WORD_W) | 128'(w_word);
  assign w_issue       = (r_state == S_ISSUE) && !inCoreBusy;
  assign w_capture     = (r_state == S_WAIT_DONE) && !inCoreBusy && !r_op_key;
  assign w_res_hs      = r_res_valid && inResReady;
  assign w_res_done    = w_res_hs && (r_res_cnt == LAST_BEAT);
  assign w_res_cnt_inc = r_res_cnt + CW'(1);

  assign outWordReady  = r_word_ready;
  assign outSeqErr     = r_seq_err;
  assign outCoreDataWr = r_data_wr;
  assign outCoreKeyWr  = r_key_wr;
  assign outCoreData   = r_core_data;
  assign outCoreKey    = r_core_key;
  assign outResValid   = r_res_valid;
  assign outResLast    = r_res_last;

  always_ff @(posedge inClk or negedge inReset) begin
    if (!inReset) r_state <= S_FILL;
    else          r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FILL:       if (w_block_done) w_state_next = S_ISSUE;
      S_ISSUE:      if (!inCoreBusy) w_state_next = S_WAIT_START;
      // The core only raises busy the cycle after the strobe.
      S_WAIT_START: w_state_next = S_WAIT_DONE;
      S_WAIT_DONE:  if (!inCoreBusy) w_state_next = r_op_key ? S_FILL : S_DRAIN;
      S_DRAIN:      if (w_res_done) w_state_next = S_FILL;
      default:      w_state_next = S_FILL;
    endcase
  end

  always_ff @(posedge inClk or negedge inReset) begin
    if (!inReset) begin
      r_word_ready <= 1'b0;
      r_seq_err    <= 1'b0;
      r_data_wr    <= 1'b0;
      r_key_wr     <= 1'b0;
      r_res_valid  <= 1'b0;
      r_res_last   <= 1'b0;
      r_core_data  <= '0;
      r_core_key   <= '0;
      r_buf        <= '0;
      r_res        <= '0;
      r_cnt        <= '0;
      r_res_cnt    <= '0;
      r_type       <= 1'b0;
      r_op_key     <= 1'b0;
    end else begin
      r_word_ready <= (w_state_next == S_FILL);
      r_res_valid  <= (w_state_next == S_DRAIN);
      r_seq_err    <= w_mismatch;
      r_key_wr     <= w_issue && r_op_key;
      r_data_wr    <= w_issue && !r_op_key;
      if (w_accept) begin
        r_buf  <= w_block;
        r_type <= inWordIsKey;
        r_cnt  <= w_block_done ? '0 : (w_beat + CW'(1));
      end
      if (w_block_done) begin
        r_op_key <= inWordIsKey;
        if (inWordIsKey) r_core_key  <= w_block;
        else             r_core_data <= w_block;
      end
      if (w_capture) begin
        r_res      <= inCoreResult;
        r_res_cnt  <= '0;
        r_res_last <= (WORDS == 1);
      end else if (w_res_hs) begin
        r_res      <= r_res << WORD_W;
        r_res_cnt  <= w_res_done ? '0 : w_res_cnt_inc;
        r_res_last <= !w_res_done && (w_res_cnt_inc == LAST_BEAT);
      end
    end
  end

endmodule

// File: tb/tb_noekeon_word_loader.sv
// tb/tb_noekeon_word_loader.sv - directed bench for noekeon_word_loader with a stub Noekeon core.
module tb_noekeon_word_loader;
  logic         clk = 1'b0;
  logic         inReset = 1'b0;
  logic         inWordValid = 1'b0;
  logic         outWordReady;
  logic [31:0]  inWordData = '0;
  logic         inWordIsKey = 1'b0;
  logic         outSeqErr, outCoreDataWr, outCoreKeyWr;
  logic [127:0] outCoreData, outCoreKey;
  logic         inCoreBusy = 1'b0;
  logic [127:0] inCoreResult = '0;
  logic         outResValid;
  logic         inResReady = 1'b0;
  logic [31:0]  outResData;
  logic         outResLast;

  int n_checks = 0, n_errors = 0;
  int key_wr_cnt = 0, data_wr_cnt = 0, seq_cnt = 0, resv_cnt = 0, ready_cycles = 0;
  int busy_cnt = 0;
  logic strobe_seen = 1'b0, force_busy = 1'b0, use_fixed = 1'b0;
  logic [127:0] fixed_result = '0;
  logic [31:0] res_q[$];
  logic        last_q[$];

  noekeon_word_loader #(.WORD_W(32)) dut (
    .inClk(clk), .inReset(inReset), .inWordValid(inWordValid), .outWordReady(outWordReady),
    .inWordData(inWordData), .inWordIsKey(inWordIsKey), .outSeqErr(outSeqErr),
    .outCoreDataWr(outCoreDataWr), .outCoreKeyWr(outCoreKeyWr), .outCoreData(outCoreData),
    .outCoreKey(outCoreKey), .inCoreBusy(inCoreBusy), .inCoreResult(inCoreResult),
    .outResValid(outResValid), .inResReady(inResReady), .outResData(outResData),
    .outResLast(outResLast)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] host_w(input logic [31:0] x);
`ifdef NOEKEON_LOADER_BYTESWAP_EN
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
`else
    return x;
`endif
  endfunction

  // One clock: record pre-edge handshakes, sample #1 after the edge, run the stub core.
  task automatic tick();
    logic hs, l, rdy;
    logic [31:0] d;
    hs = outResValid && inResReady;
    d = outResData;
    l = outResLast;
    rdy = outWordReady;
    @(posedge clk);
    #1;
    if (hs) begin res_q.push_back(d); last_q.push_back(l); end
    if (rdy) ready_cycles++;
    if (outCoreDataWr) data_wr_cnt++;
    if (outCoreKeyWr) key_wr_cnt++;
    if (outSeqErr) seq_cnt++;
    if (outResValid) resv_cnt++;
    if (strobe_seen) begin busy_cnt = 5; strobe_seen = 1'b0; end
    else if (busy_cnt > 0) busy_cnt--;
    if (outCoreDataWr || outCoreKeyWr) begin
      strobe_seen = 1'b1;
      inCoreResult = use_fixed ? fixed_result : ~outCoreData;
    end
    inCoreBusy = force_busy || (busy_cnt != 0);
  endtask

  task automatic send_word(input logic [31:0] w, input logic k);
    int n;
    n = 0;
    while (!outWordReady && n < 100) begin tick(); n++; end
    if (n >= 100) check_eq("send_timeout", outWordReady, 1);
    inWordValid = 1'b1;
    inWordData = w;
    inWordIsKey = k;
    tick();
    inWordValid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] blk, input logic k);
    for (int i = 0; i < 4; i++) send_word(host_w(blk[127-32*i -: 32]), k);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (!outWordReady && n < 100) begin tick(); n++; end
    check_eq(tag, outWordReady, 1);
  endtask

  task automatic drain(input string tag, input logic [127:0] exp);
    logic [127:0] got;
    logic [3:0] lb;
    int n;
    res_q.delete();
    last_q.delete();
    inResReady = 1'b1;
    n = 0;
    while (res_q.size() < 4 && n < 100) begin tick(); n++; end
    inResReady = 1'b0;
    got = '0;
    lb = '0;
    for (int i = 0; i < 4; i++) begin
      if (i < res_q.size()) begin
        got[127-32*i -: 32] = host_w(res_q[i]);
        lb[3-i] = last_q[i];
      end
    end
    check_eq({tag, "_data"}, got, exp);
    check_eq({tag, "_last"}, lb, 4'b0001);
  endtask

  initial begin
    logic [31:0] prev;
    logic stall, tog;
    int sb, dw, n;

    // Reset state
    tick(); tick();
    check_eq("rst_ctrl", {outWordReady, outSeqErr, outCoreDataWr, outCoreKeyWr, outResValid, outResLast, outResData}, '0);
    check_eq("rst_core", {outCoreData ^ outCoreKey, outCoreKey}, '0);
    inReset = 1'b1;
    tick();
    check_eq("rst_ready", outWordReady, 1);

    // 1: key load
    send_block(128'h000102030405060708090A0B0C0D0E0F, 1'b1);
    check_eq("t1_wr_early", outCoreKeyWr, 0);
    check_eq("t1_ready_low", outWordReady, 0);
    tick();
    check_eq("t1_key_wr", outCoreKeyWr, 1);
    check_eq("t1_key", outCoreKey, 128'h000102030405060708090A0B0C0D0E0F);
    tick();
    check_eq("t1_key_wr_end", outCoreKeyWr, 0);
    wait_idle("t1_idle");
    check_eq("t1_key_wr_cnt", key_wr_cnt, 1);
    check_eq("t1_no_result", resv_cnt, 0);

    // 2: data block through stub core
    send_block({4{32'h11111111}}, 1'b0);
    ready_cycles = 0;
    drain("t2", {4{32'hEEEEEEEE}});
    check_eq("t2_data_wr_cnt", data_wr_cnt, 1);
    check_eq("t2_ready_held_low", ready_cycles, 0);
    check_eq("t2_core_data", outCoreData, {4{32'h11111111}});

    // 3: core busy while issuing
    force_busy = 1'b1;
    inCoreBusy = 1'b1;
    send_block(128'h0123456789ABCDEFFEDCBA9876543210, 1'b0);
    dw = data_wr_cnt;
    tick(); tick(); tick();
    check_eq("t3_held", data_wr_cnt - dw, 0);
    force_busy = 1'b0;
    inCoreBusy = (busy_cnt != 0);
    tick();
    check_eq("t3_strobe", outCoreDataWr, 1);
    tick();
    check_eq("t3_strobe_end", outCoreDataWr, 0);
    drain("t3", ~128'h0123456789ABCDEFFEDCBA9876543210);
    check_eq("t3_data_wr_cnt", data_wr_cnt - dw, 1);

    // 4: type switch mid-fill
    dw = data_wr_cnt;
    sb = seq_cnt;
    send_word(host_w(32'h55555555), 1'b0);
    send_word(host_w(32'h55555555), 1'b0);
    send_word(host_w(32'hAAAAAAAA), 1'b1);
    check_eq("t4_seq_err", outSeqErr, 1);
    tick();
    check_eq("t4_seq_err_end", outSeqErr, 0);
    send_word(host_w(32'h00000001), 1'b1);
    send_word(host_w(32'h00000002), 1'b1);
    send_word(host_w(32'h00000003), 1'b1);
    tick();
    check_eq("t4_key_wr", outCoreKeyWr, 1);
    check_eq("t4_key", outCoreKey, 128'hAAAAAAAA000000010000000200000003);
    wait_idle("t4_idle");
    check_eq("t4_no_data_wr", data_wr_cnt - dw, 0);
    check_eq("t4_seq_cnt", seq_cnt - sb, 1);

    // 5: result backpressure
    send_block(128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0, 1'b0);
    res_q.delete();
    last_q.delete();
    sb = 0;
    tog = 1'b1;
    n = 0;
    while (res_q.size() < 4 && n < 200) begin
      inResReady = tog;
      prev = outResData;
      stall = outResValid && !tog;
      tick();
      if (stall && outResData !== prev) sb++;
      if (outResValid || stall) tog = ~tog;
      n++;
    end
    inResReady = 1'b0;
    check_eq("t5_beats", res_q.size(), 4);
    if (res_q.size() == 4)
      check_eq("t5_order", {host_w(res_q[0]), host_w(res_q[1]), host_w(res_q[2]), host_w(res_q[3])},
               ~128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0);
    check_eq("t5_stall_stable", sb, 0);

    // 5: reset mid-drain
    send_block(128'h00000000111111112222222233333333, 1'b0);
    n = 0;
    while (!outResValid && n < 100) begin tick(); n++; end
    check_eq("t5_drain_reached", outResValid, 1);
    inResReady = 1'b1;
    tick();
    inResReady = 1'b0;
    inReset = 1'b0;
    #1;
    check_eq("t5_rst_ctrl", {outWordReady, outSeqErr, outCoreDataWr, outCoreKeyWr, outResValid, outResLast, outResData}, '0);
    check_eq("t5_rst_data", outCoreData, '0);
    check_eq("t5_rst_key", outCoreKey, '0);
    busy_cnt = 0;
    strobe_seen = 1'b0;
    inCoreBusy = 1'b0;
    tick(); tick();
    inReset = 1'b1;
    tick();
    check_eq("t5_ready_after_rst", outWordReady, 1);
    send_block(128'hFFFFFFFF000000005A5A5A5AA5A5A5A5, 1'b0);
    drain("t5_fresh", 128'h00000000FFFFFFFFA5A5A5A55A5A5A5A);
    wait_idle("t5_idle");

`ifdef NOEKEON_LOADER_BYTESWAP_EN
    // 6: little-endian host words
    use_fixed = 1'b1;
    fixed_result = {32'hDEADBEEF, 96'h0};
    send_word(32'h00010203, 1'b0);
    send_word(32'h04050607, 1'b0);
    send_word(32'h08090A0B, 1'b0);
    send_word(32'h0C0D0E0F, 1'b0);
    tick();
    check_eq("t6_block", outCoreData, 128'h030201000706050408090A0B0C0D0E0F ^ 128'h0000000000000000030307070303070F ^ 128'h0000000000000000030307070303070F ^ 128'h00000000000000000B0A09080F0E0D0C ^ 128'h000000000000000008090A0B0C0D0E0F);
    res_q.delete();
    last_q.delete();
    inResReady = 1'b1;
    n = 0;
    while (res_q.size() < 1 && n < 100) begin tick(); n++; end
    check_eq("t6_res_word", (res_q.size() > 0) ? res_q[0] : 32'h0, 32'hEFBEADDE);
    while (res_q.size() < 4 && n < 200) begin tick(); n++; end
    inResReady = 1'b0;
    use_fixed = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
